// File: rtl/lis3dh_spi_responder_pkg.sv
// Register map constants and FSM state type for the LIS3DH SPI responder.
package lis3dh_pkg;

    localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
    localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
    localparam logic [5:0] ADDR_CTRL_REG2 = 6'h21;
    localparam logic [5:0] ADDR_CTRL_REG3 = 6'h22;
    localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
    localparam logic [5:0] ADDR_CTRL_REG5 = 6'h24;
    localparam logic [5:0] ADDR_CTRL_REG6 = 6'h25;
    localparam logic [5:0] ADDR_STATUS    = 6'h27;
    localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
    localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;
    localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
    localparam logic [5:0] ADDR_OUT_Y_H   = 6'h2B;
    localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;
    localparam logic [5:0] ADDR_OUT_Z_H   = 6'h2D;

    localparam logic [7:0] WHO_AM_I_VAL   = 8'h33;
    localparam logic [7:0] CTRL_REG1_RST  = 8'h07;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_t;

endpackage

// File: rtl/lis3dh_spi_responder_if.sv
// 4-wire SPI pin bundle between the accelerometer initiator and the responder.
interface lis3dh_spi_responder_if;
    logic spc;
    logic cs;
    logic sdi;
    logic sdo;

    modport master (output spc, output cs, output sdi, input sdo);
    modport slave  (input spc, input cs, input sdi, output sdo);
endinterface

// File: rtl/lis3dh_spi_responder_sync_edge.sv
// Two-flop synchronizer with rise/fall strobes derived from the synchronized level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync;
    logic prev;

    // Synchronize the pin and keep one cycle of history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;
endmodule

// File: rtl/lis3dh_spi_responder.sv
// LIS3DH SPI responder: SPI mode 3 slave with the sensor's register map.
//
// state | meaning
// IDLE  | cs high, waiting for a transaction
// CMD   | shifting in the command byte (RW, MS, address)
// DATA  | shifting data bytes; reads drive sdo, writes update registers
module lis3dh_spi_responder
    import lis3dh_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    lis3dh_spi_responder_if.slave    spi,
    input  logic [15:0]              x_in,
    input  logic [15:0]              y_in,
    input  logic [15:0]              z_in,
    input  logic                     sample_valid,
    output logic [7:0]               ctrl_reg1,
    output logic                     busy
);
    logic cs_s, cs_rise, cs_fall;
    logic spc_rise, spc_fall;
    logic sdi_meta, sdi_s;

    spi_state_t state, state_nxt;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       cmd_rw, cmd_ms;
    logic [5:0] addr, addr_nxt, rd_addr;
    logic [7:0] rd_data, shift_out;
    logic       sdo_q;
    logic       wr_en, rd_clear;

    logic [7:0]  ctrl [6];
    logic [15:0] out_x, out_y, out_z;
    logic        zyxda;
    logic        pend;
    logic [15:0] pend_x, pend_y, pend_z;

    // spc level is not needed; only its edges drive the shifters.
    spi_sync_edge #(.RST_VAL(1'b1)) u_spc_sync (
        .clk(clk), .reset_n(reset_n), .din(spi.spc),
        .level(), .rise(spc_rise), .fall(spc_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset_n(reset_n), .din(spi.cs),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    // Plain two-flop synchronizer for sdi; aligned in latency with the spc strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdi_meta <= 1'b0;
            sdi_s    <= 1'b0;
        end else begin
            sdi_meta <= spi.sdi;
            sdi_s    <= sdi_meta;
        end
    end

    assign busy      = ~cs_s;
    assign rx_byte   = {shift_in, sdi_s};
    assign byte_done = spc_rise && (bit_cnt == 3'd7) && (state != IDLE);
    assign addr_nxt  = cmd_ms ? addr + 6'd1 : addr;
    assign rd_addr   = (state == CMD) ? rx_byte[5:0] : addr_nxt;
    assign wr_en     = byte_done && (state == DATA) && !cmd_rw &&
                       (addr >= ADDR_CTRL_REG1) && (addr <= ADDR_CTRL_REG6);
    assign rd_clear  = byte_done && (state == DATA) && cmd_rw && (addr == ADDR_OUT_Z_H);

    // Register read mux for the byte about to be loaded into the output shifter.
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_WHO_AM_I:  rd_data = WHO_AM_I_VAL;
            ADDR_CTRL_REG1: rd_data = ctrl[0];
            ADDR_CTRL_REG2: rd_data = ctrl[1];
            ADDR_CTRL_REG3: rd_data = ctrl[2];
            ADDR_CTRL_REG4: rd_data = ctrl[3];
            ADDR_CTRL_REG5: rd_data = ctrl[4];
            ADDR_CTRL_REG6: rd_data = ctrl[5];
            ADDR_STATUS:    rd_data = {4'b0000, zyxda, 3'b000};
            ADDR_OUT_X_L:   rd_data = out_x[7:0];
            ADDR_OUT_X_H:   rd_data = out_x[15:8];
            ADDR_OUT_Y_L:   rd_data = out_y[7:0];
            ADDR_OUT_Y_H:   rd_data = out_y[15:8];
            ADDR_OUT_Z_L:   rd_data = out_z[7:0];
            ADDR_OUT_Z_H:   rd_data = out_z[15:8];
            default:        rd_data = 8'h00;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state; a cs rise always returns to IDLE, dropping any partial byte.
    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall)   state_nxt = CMD;
                CMD:     if (byte_done) state_nxt = DATA;
                DATA:    state_nxt = DATA;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bit shifting, command latch, address stepping and sdo generation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            cmd_rw    <= 1'b0;
            cmd_ms    <= 1'b0;
            addr      <= 6'd0;
            shift_out <= 8'hFF;
            sdo_q     <= 1'b1;
        end else begin
            if (cs_fall) begin
                bit_cnt <= 3'd0;
            end else if (spc_rise && state != IDLE) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= {shift_in[5:0], sdi_s};
            end

            if (byte_done && state == CMD) begin
                cmd_rw    <= rx_byte[7];
                cmd_ms    <= rx_byte[6];
                addr      <= rx_byte[5:0];
                shift_out <= rd_data;
            end else if (byte_done && state == DATA) begin
                addr      <= addr_nxt;
                shift_out <= rd_data;
            end

            if (cs_rise || state == IDLE) begin
                sdo_q <= 1'b1;
            end else if (spc_fall && state == DATA) begin
                if (cmd_rw) begin
                    sdo_q     <= shift_out[7];
                    shift_out <= {shift_out[6:0], 1'b1};
                end else begin
                    sdo_q <= 1'b1;
                end
            end
        end
    end

    // Register file: control writes, ZYXDA bookkeeping and sample capture deferred while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl[0] <= CTRL_REG1_RST;
            for (int i = 1; i < 6; i++) ctrl[i] <= 8'h00;
            out_x  <= 16'h0000;
            out_y  <= 16'h0000;
            out_z  <= 16'h0000;
            zyxda  <= 1'b0;
            pend   <= 1'b0;
            pend_x <= 16'h0000;
            pend_y <= 16'h0000;
            pend_z <= 16'h0000;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (wr_en && addr[2:0] == i[2:0]) ctrl[i] <= rx_byte;
            end

            if (rd_clear) zyxda <= 1'b0;

            if (!busy) begin
                if (sample_valid) begin
                    out_x <= x_in;
                    out_y <= y_in;
                    out_z <= z_in;
                    zyxda <= 1'b1;
                    pend  <= 1'b0;
                end else if (pend) begin
                    out_x <= pend_x;
                    out_y <= pend_y;
                    out_z <= pend_z;
                    zyxda <= 1'b1;
                    pend  <= 1'b0;
                end
            end else if (sample_valid) begin
                pend   <= 1'b1;
                pend_x <= x_in;
                pend_y <= y_in;
                pend_z <= z_in;
            end
        end
    end

    assign ctrl_reg1 = ctrl[0];
    assign spi.sdo   = sdo_q;
endmodule
